regfile_vec_param: RTL and testbench
====================================

# regfile_vec_param

Parametrised successor to the CPU vector register file. It holds NREGS-1 general vector registers of LANES x WIDTH bits and aliases the top index to an externally driven vector (the PC-style r15). New over the previous generation: per-lane write mask, same-cycle write-to-read bypass, a sequential zeroing engine driven by reset or an explicit clear request, and a dropped-write flag. It sits in the decode stage of the vector pipeline and feeds both ALU operand buses.

## Interface
- LANES, default 3: lanes per vector register.
- WIDTH, default 18: bits per lane.
- NREGS, default 16: architectural registers, including the aliased top index; minimum 4.
- AW, default $clog2(NREGS): address width (derived).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request to zero all general registers; sampled only when not busy.
- busy  out  1  clear sequence in progress.
- we  in  1  write enable.
- wmask  in  LANES  per-lane write enable; lane i is written only if we and wmask[i] are both 1.
- wa  in  AW  write address.
- wd  in  LANES x WIDTH  write data.
- rext  in  LANES x WIDTH  value returned for address NREGS-1.
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  LANES x WIDTH  combinational read data.
- wr_drop  out  1  one-cycle pulse, registered, flags a write request that was discarded.

## Operation
- Storage: NREGS-1 entries, indices 0..NREGS-2. Index NREGS-1 is never stored. Reads at that index return rext. Writes to it are discarded.
- FSM states:
  - IDLE: busy=0.
  - CLEAR: busy=1. Holds pointer ptr (AW bits).
- Transitions:
  - rst=1 forces CLEAR with ptr=0, from any state, including mid-clear.
  - IDLE with clr_req=1 goes to CLEAR with ptr=0.
  - CLEAR zeroes all lanes of entry ptr each cycle, then increments ptr.
  - When entry NREGS-2 is zeroed, the FSM returns to IDLE.
  - clr_req is ignored while in CLEAR. It does not restart the sequence.
- Writes:
  - Accepted only in IDLE with wa != NREGS-1.
  - Masked-off lanes keep their old value.
  - we=1 with wmask=0 is a legal no-op and does not count as a drop.
- Drops:
  - A write is dropped when we=1 and either busy=1 or wa=NREGS-1.
  - wr_drop is asserted the following cycle for exactly one cycle per dropped request.
- Reads while busy=1: general indices return all zeros, because they are architecturally zero. Index NREGS-1 still returns rext.
- Bypass:
  - Applies in IDLE when we=1, ra==wa and wa != NREGS-1.
  - Lanes with wmask[i]=1 return wd lane i. Other lanes return stored data.
  - The bypass applies to rd1 and rd2 independently.
- Same-cycle clr_req and we in IDLE: the write commits. The clear then starts next cycle and overwrites it.

## Timing
- Reset values:
  - After the rst edge: busy=1, ptr=0, wr_drop=0.
  - rd1/rd2 read zero for general indices and rext for the top index.
- Clear latency: busy stays high for exactly NREGS-1 cycles after the last cycle with rst=1. That is 15 cycles at the defaults.
- The first accepted write is on the cycle busy is first sampled low.
- Write latency: the entry updates on the clk edge. Same-cycle reads see the new value through the bypass.
- Read latency: zero, purely combinational from ra*, wa/wd/we/wmask, rext and the state.
- wr_drop: registered, one cycle after the offending request. It clears on rst.

## Structure
- Shared package regfile_vec_pkg:
  - Default LANES and WIDTH.
  - typedef lane_t, WIDTH bits.
  - typedef vec_t, LANES x lane_t.
  - Enum clr_state_t {IDLE, CLEAR}.
- One sub-module, regfile_vec_clr_fsm:
  - Holds the state register and ptr.
  - Drives busy, a clear-write strobe and the clear index.
  - The top level muxes the clear strobe against the normal write path.

## Test plan
- Reset and clear: pulse rst for 2 cycles.
  - busy stays high for 15 cycles, then falls.
  - rd1 at ra1=3 reads 0 throughout.
  - With rext=3'h{1,2,3}, ra2=15 reads rext.
- Masked write: write wa=5, wd={18'h3FFFF, 18'h00001, 18'h2AAAA} with wmask=3'b111. Next cycle write wa=5, wd all 18'h0 with wmask=3'b010.
  - Reading ra1=5 returns {18'h3FFFF, 18'h0, 18'h2AAAA}.
- Bypass: with entry 7 holding zeros, drive we=1, wa=7, wmask=3'b001, wd lane0=18'h12345, and ra1=ra2=7 in the same cycle.
  - Both reads show lane0=18'h12345 and lanes 1-2=0 combinationally.
- Drops: write wa=15 while idle, then write wa=2 during busy.
  - wr_drop pulses one cycle after each request.
  - rd at 2 stays 0.
  - rd at 15 still equals rext.
- Clear request:
  - With entries 1 and 9 nonzero, assert clr_req together with a write to wa=4. busy rises next cycle and stays high for 15 cycles; afterwards entries 1, 4 and 9 read 0.
  - A clr_req mid-clear does not extend busy.
- Reset mid-clear: assert rst at cycle 8 of a clear.
  - busy stays high for 15 cycles after rst deasserts.
  - All entries read 0.

Source files
------------

// File: rtl/regfile_vec_pkg.sv
// Shared types and defaults for the parametrised vector register file.
package regfile_vec_pkg;

  localparam int LANES_DEF = 3;
  localparam int WIDTH_DEF = 18;

  typedef logic [WIDTH_DEF-1:0] lane_t;
  typedef lane_t [LANES_DEF-1:0] vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_vec_clr_fsm.sv
// Sequential zeroing engine: walks every general entry once after reset or an
// explicit clear request, emitting one clear-write per cycle.
module regfile_vec_clr_fsm
  import regfile_vec_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 2);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  // State and pointer register; reset restarts the sweep even mid-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: a request is only honoured from IDLE, so it never extends a sweep.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_we  = busy;
  assign clr_idx = ptr;

endmodule

// File: rtl/regfile_vec_param.sv
// Vector register file: NREGS-1 stored entries of LANES x WIDTH bits, top index
// aliased to rext, per-lane write mask, write-to-read bypass, clear engine and
// a registered dropped-write flag.
module regfile_vec_param
  import regfile_vec_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   we,
  input  logic [LANES-1:0]       wmask,
  input  logic [AW-1:0]          wa,
  input  logic [LANES*WIDTH-1:0] wd,
  input  logic [LANES*WIDTH-1:0] rext,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic [LANES*WIDTH-1:0] rd1,
  output logic [LANES*WIDTH-1:0] rd2,
  output logic                   wr_drop
);

  localparam int            VW  = LANES * WIDTH;
  localparam logic [AW-1:0] TOP = AW'(NREGS - 1);

  logic [VW-1:0] regs [NREGS-1];
  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          wr_ok;

  regfile_vec_clr_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_ok = we && !busy && (wa != TOP);

  // One read port: alias, architectural zero while clearing, else stored data
  // with masked lanes of a same-cycle write forwarded.
  function automatic logic [VW-1:0] read_port(input logic [AW-1:0] ra,
                                              input logic [VW-1:0] stored);
    logic [VW-1:0] v;
    if (ra == TOP) begin
      v = rext;
    end else if (busy) begin
      v = '0;
    end else begin
      v = stored;
      if (wr_ok && (ra == wa)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) v[i*WIDTH +: WIDTH] = wd[i*WIDTH +: WIDTH];
        end
      end
    end
    return v;
  endfunction

  // Storage update: clear sweep has priority; otherwise a masked normal write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) regs[wa][i*WIDTH +: WIDTH] <= wd[i*WIDTH +: WIDTH];
      end
    end
  end

  // Flag any write request that arrives while clearing or targets the alias.
  always_ff @(posedge clk) begin
    if (rst) wr_drop <= 1'b0;
    else     wr_drop <= we && (busy || (wa == TOP));
  end

  // Combinational read ports; the alias index is never used to index storage.
  always_comb begin
    logic [VW-1:0] s1, s2;
    s1  = (ra1 != TOP) ? regs[ra1] : '0;
    s2  = (ra2 != TOP) ? regs[ra2] : '0;
    rd1 = read_port(ra1, s1);
    rd2 = read_port(ra2, s2);
  end

endmodule

// File: tb/tb_regfile_vec_param.sv
// Bench for regfile_vec_param: directed scenarios plus random traffic against
// a lane-level array model with a clear countdown.
module tb_regfile_vec_param;
  import regfile_vec_pkg::*;

  logic        clk;
  logic        rst, clr_req, busy, we, wr_drop;
  logic [2:0]  wmask;
  logic [3:0]  wa, ra1, ra2;
  logic [53:0] wd, rext, rd1, rd2;

  regfile_vec_param dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy), .we(we),
    .wmask(wmask), .wa(wa), .wd(wd), .rext(rext), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t model [15];
  int   left;
  bit   valid;
  int   n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] exp_rd(input logic [3:0] ra);
    vec_t v;
    if (ra == 4'd15) return rext;
    if (left > 0) return '0;
    v = model[ra];
    if (we && wa == ra)
      for (int i = 0; i < 3; i++) if (wmask[i]) v[i] = wd[i*18 +: 18];
    return v;
  endfunction

  task automatic zero_model();
    for (int k = 0; k < 15; k++) model[k] = '0;
  endtask

  task automatic drive(input bit r, input bit c, input bit w, input logic [2:0] m,
                       input logic [3:0] a, input logic [53:0] d,
                       input logic [3:0] r1, input logic [3:0] r2);
    rst = r; clr_req = c; we = w; wmask = m; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  task automatic tick();
    bit ed;
    #1;
    if (valid) begin
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
    end
    ed = !rst && we && (left > 0 || wa == 4'd15);
    @(posedge clk);
    if (rst) begin
      left = 15; zero_model(); valid = 1;
    end else if (left > 0) begin
      left--;
    end else begin
      if (we && wa != 4'd15)
        for (int i = 0; i < 3; i++) if (wmask[i]) model[wa][i] = wd[i*18 +: 18];
      if (clr_req) begin left = 15; zero_model(); end
    end
    #1;
    if (valid) begin
      check("busy", busy, left > 0);
      check("wr_drop", wr_drop, ed);
    end
  endtask

  task automatic run_clear(output int cnt, input bit poke);
    cnt = 0;
    while (busy && cnt < 40) begin
      drive(0, poke && cnt == 5, 0, 0, 0, 0, 3, 15);
      tick();
      cnt++;
    end
  endtask

  initial begin
    clk = 0; valid = 0; left = 0;
    rext = {18'd1, 18'd2, 18'd3};
    drive(0, 0, 0, 0, 0, 0, 3, 15);
    @(posedge clk); #1;

    // reset and clear length
    drive(1, 0, 0, 0, 0, 0, 3, 15);
    tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_drop", wr_drop, 0);
    run_clear(n, 0);
    check("clr_len_rst", n, 15);

    // masked write
    drive(0, 0, 1, 3'b111, 5, {18'h3FFFF, 18'h00001, 18'h2AAAA}, 5, 5); tick();
    drive(0, 0, 1, 3'b010, 5, 54'h0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 5, 5); #1;
    check("mask_lit", rd1, {18'h3FFFF, 18'h0, 18'h2AAAA});
    tick();

    // bypass
    drive(0, 0, 1, 3'b001, 7, {18'h3FFFF, 18'h3FFFF, 18'h12345}, 7, 7); #1;
    check("byp_rd1", rd1, 54'h12345);
    check("byp_rd2", rd2, 54'h12345);
    tick();

    // drops
    drive(0, 0, 1, 3'b111, 15, {3{18'h15555}}, 2, 15); tick();
    check("drop_top", wr_drop, 1);
    drive(0, 0, 0, 0, 0, 0, 2, 15); tick();
    check("drop_gone", wr_drop, 0);
    drive(0, 1, 0, 0, 0, 0, 2, 15); tick();
    drive(0, 0, 1, 3'b111, 2, {3{18'h3FFFF}}, 2, 15); tick();
    check("drop_busy", wr_drop, 1);
    run_clear(n, 0);
    drive(0, 0, 0, 0, 0, 0, 2, 15); #1;
    check("drop_rd2", rd1, 0);
    check("drop_alias", rd2, rext);
    tick();

    // clear request with coincident write, clr_req mid-clear ignored
    drive(0, 0, 1, 3'b111, 1, {3{18'h00ABC}}, 1, 9); tick();
    drive(0, 0, 1, 3'b101, 9, {3{18'h01234}}, 1, 9); tick();
    drive(0, 1, 1, 3'b111, 4, {3{18'h2BCDE}}, 4, 4); tick();
    check("clrq_busy", busy, 1);
    run_clear(n, 1);
    check("clr_len_req", n, 15);
    drive(0, 0, 0, 0, 0, 0, 1, 4); #1;
    check("clr_e1", rd1, 0);
    check("clr_e4", rd2, 0);
    ra1 = 9; #1;
    check("clr_e9", rd1, 0);
    tick();

    // reset mid-clear
    drive(0, 0, 1, 3'b111, 6, {3{18'h1F0F0}}, 6, 6); tick();
    drive(0, 1, 0, 0, 0, 0, 6, 6); tick();
    for (int k = 0; k < 8; k++) begin drive(0, 0, 0, 0, 0, 0, 6, 15); tick(); end
    drive(1, 0, 0, 0, 0, 0, 6, 15); tick();
    run_clear(n, 0);
    check("clr_len_midrst", n, 15);
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 0, 0, 0, 0, 4'(k), 4'(14 - k)); tick();
    end

    // random traffic
    for (int k = 0; k < 800; k++) begin
      rext = {$urandom_range(0, 18'h3FFFF), $urandom_range(0, 18'h3FFFF),
              $urandom_range(0, 18'h3FFFF)};
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom),
            {18'($urandom), 18'($urandom), 18'($urandom)},
            4'($urandom), ($urandom_range(0, 1) == 1) ? wa : 4'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
